vga_raster_scan: RTL and testbench
==================================

Name: vga_raster_scan

Overview:
- Upstream/downstream companion of the point-in-triangle tester in the VGA triangle-drawing design.
- Generates VGA pixel timing and drives the current pixel coordinate into the tester as pix_x/pix_y.
- Consumes the tester's inside flag (tri_in) and produces registered, blank-gated 4:4:4 RGB with hsync/vsync aligned to the colour.
- A PIPE-deep delay line covers any latency the tester adds.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- SYNC_POL, 0, active sync level (0 = active-low)
- PIPE, 0, pixel ticks between pix_x/pix_y and the matching tri_in (0..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  run scan; low = freeze and blank
- pix_x  out  12  current horizontal counter (to tester pToX)
- pix_y  out  12  current vertical counter (to tester pToY)
- pix_valid  out  1  current counter is inside the active area
- tri_in  in  1  tester result for the coordinate issued PIPE ticks earlier
- fg_rgb  in  12  colour inside triangle {R[11:8],G[7:4],B[3:0]}
- bg_rgb  in  12  colour outside triangle
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_start  out  1  one-clk pulse at start of each frame

Behaviour:
- Timing constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (rst_n low at a clk edge):
  - divider, hcnt, vcnt and all delay-line stages cleared to 0.
  - vga_r/g/b = 0; hsync = vsync = ~SYNC_POL; frame_start = 0.
  - pix_valid is forced to 0 while rst_n is low.
- Divider: counts 0..CLK_DIV-1. tick = (div == CLK_DIV-1). With CLK_DIV = 1, tick is high every cycle.
- Counters, on tick:
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps to 0 after V_TOTAL-1.
  - Both counters are 12-bit unsigned.
- Coordinate outputs (combinational from the counters):
  - pix_x = hcnt, pix_y = vcnt.
  - pix_valid = enable & rst_n & (hcnt < H_ACTIVE) & (vcnt < V_ACTIVE).
- Raw sync: hs_raw active when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vs_raw uses the same rule on vcnt with the vertical constants. Both are full-line (vsync is not pixel-offset).
- Delay line: pix_valid, hs_raw and vs_raw are shifted PIPE stages on tick. With PIPE = 0 there is no delay.
- Output register, updated on tick only:
  - rgb = delayed_valid ? (tri_in ? fg_rgb : bg_rgb) : 12'h000.
  - hsync = delayed_hs ? SYNC_POL : ~SYNC_POL; vsync the same way.
  - Latency from counter value to pins: PIPE+1 pixel ticks. Sync and colour stay mutually aligned.
- frame_start: high for exactly one clk, on the tick where hcnt and vcnt both wrap to 0.
- enable low:
  - divider held at 0; counters and delay line hold their values.
  - rgb forced to 0 and syncs forced inactive on the next clk edge, not waiting for tick.
  - frame_start = 0.
  - When enable returns, scanning resumes from the held position.
- Simultaneous reset and enable: reset wins.
- Reset mid-frame: on the next clk edge everything returns to the reset state and the scan restarts at (0,0). No partial-line recovery.
- tri_in is only sampled on tick. Its value outside tick cycles is ignored.

Test Plan:
- Reset hold: rst_n=0 for 5 clks with enable=1 -> pix_x=0, pix_y=0, pix_valid=0, rgb=000, hsync=vsync=1 (SYNC_POL=0). Release rst_n -> pix_valid=1 and pix_x advances every 2 clks.
- Line timing, default params, CLK_DIV=2: count clks between hsync falling edges -> 1600. hsync low for 192 clks. hsync falls at pin latency 1 tick after hcnt=656.
- Frame timing: frame_start period = 840000 clks. vsync low for 2 lines (3200 clks), starting after line 489 ends.
- Colour/blanking with PIPE=0, fg=F00, bg=00F: tri_in=1 at (25,25) -> pins F,0,0 one tick later. tri_in=0 -> 0,0,F. hcnt=640 with tri_in=1 -> 000.
- Pipeline alignment with PIPE=2, small params (H 8/2/2/2, V 4/1/1/1), CLK_DIV=1, tri_in driven from a 2-stage model of (pix_x<4): rgb is fg exactly for hcnt 0..3 of each visible line. hsync stays aligned: rgb=000 throughout hsync-active.
- Enable gating: drop enable at (100,50) for 10 clks -> rgb=000 and syncs inactive from the next edge, pix_x stays 100. Re-enable -> pix_x=101 after one tick and the frame period stretches by exactly 10 clks.

Source files
------------

// File: rtl/vga_raster_scan.sv
// VGA raster scanner: pixel-tick divider, h/v counters, coordinate feed to the
// triangle tester and a registered, blank-gated RGB/sync output stage.
module vga_raster_scan #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0,
    parameter int PIPE     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        pix_valid,
    input  logic        tri_in,
    input  logic [11:0] fg_rgb,
    input  logic [11:0] bg_rgb,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             tick, h_wrap, v_wrap;
    logic             hs_raw, vs_raw;
    logic [2:0]       cur_bits, dly_bits;
    logic [11:0]      rgb_q;
    logic             hs_q, vs_q, fs_q;

    // Divider sits at 0 while disabled so a resumed scan keeps its pixel phase.
    assign tick   = enable && (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap = (hcnt_q == 12'(H_TOTAL - 1));
    assign v_wrap = (vcnt_q == 12'(V_TOTAL - 1));

    always_comb begin
        div_d  = div_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (!enable || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (tick) begin
            if (h_wrap) begin
                hcnt_d = '0;
                vcnt_d = v_wrap ? 12'd0 : vcnt_q + 12'd1;
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign pix_x     = hcnt_q;
    assign pix_y     = vcnt_q;
    assign pix_valid = enable && rst_n && (hcnt_q < 12'(H_ACTIVE)) && (vcnt_q < 12'(V_ACTIVE));

    assign hs_raw = (hcnt_q >= 12'(H_ACTIVE + H_FP)) && (hcnt_q < 12'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw = (vcnt_q >= 12'(V_ACTIVE + V_FP)) && (vcnt_q < 12'(V_ACTIVE + V_FP + V_SYNC));
    assign cur_bits = {pix_valid, hs_raw, vs_raw};

    // Valid/sync travel through the same PIPE stages as the tester's result.
    generate
        if (PIPE == 0) begin : g_nopipe
            assign dly_bits = cur_bits;
        end else begin : g_pipe
            for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
                logic [2:0] stage_q;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            stage_q <= '0;
                        end else if (tick) begin
                            stage_q <= cur_bits;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            stage_q <= '0;
                        end else if (tick) begin
                            stage_q <= g_stage[gi-1].stage_q;
                        end
                    end
                end
            end
            assign dly_bits = g_stage[PIPE-1].stage_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= ~SYNC_ACT;
            vs_q  <= ~SYNC_ACT;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= tick && h_wrap && v_wrap;
            if (!enable) begin
                rgb_q <= '0;
                hs_q  <= ~SYNC_ACT;
                vs_q  <= ~SYNC_ACT;
            end else if (tick) begin
                rgb_q <= dly_bits[2] ? (tri_in ? fg_rgb : bg_rgb) : 12'h000;
                hs_q  <= dly_bits[1] ? SYNC_ACT : ~SYNC_ACT;
                vs_q  <= dly_bits[0] ? SYNC_ACT : ~SYNC_ACT;
            end
        end
    end

    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_raster_scan.sv
// Directed bench for vga_raster_scan on shrunken timing (H 8/2/2/2, V 4/1/1/1):
// instance A uses CLK_DIV=2/PIPE=0, instance B uses CLK_DIV=1/PIPE=2.
module tb_vga_raster_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_a = 1'b1;
    logic        enable_b = 1'b1;
    logic [11:0] fg = 12'hF00;
    logic [11:0] bg = 12'h00F;

    logic [11:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic        pix_valid_a, pix_valid_b;
    logic        tri_a, tri_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hsync_a, vsync_a, fs_a, hsync_b, vsync_b, fs_b;
    logic [1:0]  tri_pipe = 2'b00;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tester stand-ins: A answers immediately, B through a 2-tick pipeline.
    assign tri_a = (pix_x_a < 12'd4);
    always @(posedge clk) tri_pipe <= {tri_pipe[0], (pix_x_b < 12'd4)};
    assign tri_b = tri_pipe[1];

    vga_raster_scan #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(0), .PIPE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a),
        .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_valid(pix_valid_a),
        .tri_in(tri_a), .fg_rgb(fg), .bg_rgb(bg),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a)
    );

    vga_raster_scan #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(0), .PIPE(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_valid(pix_valid_b),
        .tri_in(tri_b), .fg_rgb(fg), .bg_rgb(bg),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Step A to the first negedge showing (x,y).
    task automatic wait_a(input int x, input int y);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (pix_x_a == 12'(x) && pix_y_a == 12'(y)) break;
        end
        if (n >= 2000) check("wait_a_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_hs_fall(output int t);
        logic prev;
        int   n;
        t = 0;
        prev = hsync_a;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (prev && !hsync_a) begin
                t = cyc;
                break;
            end
            prev = hsync_a;
        end
        if (n >= 2000) check("hs_fall_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_vs_fall(output int t);
        logic prev;
        int   n;
        t = 0;
        prev = vsync_a;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (prev && !vsync_a) begin
                t = cyc;
                break;
            end
            prev = vsync_a;
        end
        if (n >= 2000) check("vs_fall_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_fs(output int t);
        int n;
        t = 0;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (fs_a) begin
                t = cyc;
                break;
            end
        end
        if (n >= 2000) check("fs_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int t0, t1, w;
        int hx [0:127];
        int hy [0:127];
        int ex, ey;
        logic [11:0] exp_rgb;

        // Reset hold with enable high.
        repeat (5) @(negedge clk);
        check("rst_pix_x", 32'(pix_x_a), 32'd0);
        check("rst_pix_y", 32'(pix_y_a), 32'd0);
        check("rst_valid", 32'(pix_valid_a), 32'd0);
        check("rst_rgb", 32'({r_a, g_a, b_a}), 32'h000);
        check("rst_hsync", 32'(hsync_a), 32'd1);
        check("rst_vsync", 32'(vsync_a), 32'd1);
        check("rst_fs", 32'(fs_a), 32'd0);
        check("rst_b_hsync", 32'(hsync_b), 32'd1);
        rst_n = 1'b1;
        #1;
        check("rel_valid", 32'(pix_valid_a), 32'd1);
        @(negedge clk);
        check("rel_x_hold", 32'(pix_x_a), 32'd0);
        @(negedge clk);
        check("rel_x_step", 32'(pix_x_a), 32'd1);

        // Line timing: 14 px * 2 clk per line, 2 px of hsync.
        wait_hs_fall(t0);
        check("hs_fall_x", 32'(pix_x_a), 32'd11);
        wait_hs_fall(t1);
        check("line_period", 32'(t1 - t0), 32'd28);
        w = 1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (hsync_a) break;
            w++;
        end
        check("hs_width", 32'(w), 32'd4);

        // Frame timing: 7 lines * 28 clk, one line of vsync.
        wait_vs_fall(t0);
        check("vs_fall_y", 32'(pix_y_a), 32'd5);
        check("vs_fall_x", 32'(pix_x_a), 32'd1);
        w = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (vsync_a) break;
            w++;
        end
        check("vs_width", 32'(w), 32'd28);
        wait_fs(t0);
        check("fs_at_origin", 32'({pix_x_a, pix_y_a}), 32'd0);
        @(negedge clk);
        check("fs_one_clk", 32'(fs_a), 32'd0);
        wait_fs(t1);
        check("frame_period", 32'(t1 - t0), 32'd196);

        // Colour/blanking: pins show the pixel one tick before the counter.
        wait_a(3, 1);
        check("rgb_in_x2", 32'({r_a, g_a, b_a}), 32'hF00);
        wait_a(4, 1);
        check("rgb_in_x3", 32'({r_a, g_a, b_a}), 32'hF00);
        wait_a(5, 1);
        check("rgb_out_x4", 32'({r_a, g_a, b_a}), 32'h00F);
        wait_a(8, 1);
        check("rgb_out_x7", 32'({r_a, g_a, b_a}), 32'h00F);
        wait_a(9, 1);
        check("rgb_blank_x8", 32'({r_a, g_a, b_a}), 32'h000);
        wait_a(11, 1);
        check("hs_act_x10", 32'(hsync_a), 32'd0);
        check("rgb_in_hs", 32'({r_a, g_a, b_a}), 32'h000);
        wait_a(13, 1);
        check("hs_idle_x12", 32'(hsync_a), 32'd1);
        wait_a(3, 4);
        check("rgb_blank_y4", 32'({r_a, g_a, b_a}), 32'h000);

        // Enable gating: 10 clk pause at (5,2) stretches the frame by 10 clk.
        wait_fs(t0);
        wait_a(5, 2);
        check("pre_pause_rgb", 32'({r_a, g_a, b_a}), 32'h00F);
        enable_a = 1'b0;
        #1;
        check("pause_valid", 32'(pix_valid_a), 32'd0);
        @(posedge clk);
        #1;
        check("pause_rgb", 32'({r_a, g_a, b_a}), 32'h000);
        check("pause_hsync", 32'(hsync_a), 32'd1);
        check("pause_vsync", 32'(vsync_a), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        check("pause_x_hold", 32'(pix_x_a), 32'd5);
        check("pause_fs", 32'(fs_a), 32'd0);
        @(negedge clk);
        enable_a = 1'b1;
        @(posedge clk);
        #1;
        check("resume_x_hold", 32'(pix_x_a), 32'd5);
        @(posedge clk);
        #1;
        check("resume_x_step", 32'(pix_x_a), 32'd6);
        check("resume_rgb", 32'({r_a, g_a, b_a}), 32'h00F);
        wait_fs(t1);
        check("stretched_period", 32'(t1 - t0), 32'd206);

        // Reset mid-frame restarts at the origin.
        wait_a(6, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_xy", 32'({pix_x_a, pix_y_a}), 32'd0);
        check("midrst_rgb", 32'({r_a, g_a, b_a}), 32'h000);
        check("midrst_valid", 32'(pix_valid_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PIPE=2 instance: pins at negedge n reflect the counter seen at n-3.
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            hx[i] = int'(pix_x_b);
            hy[i] = int'(pix_y_b);
            if (i >= 3) begin
                ex = hx[i-3];
                ey = hy[i-3];
                if (ex < 8 && ey < 4) exp_rgb = (ex < 4) ? 12'hF00 : 12'h00F;
                else                  exp_rgb = 12'h000;
                check($sformatf("b_rgb(%0d,%0d)", ex, ey), 32'({r_b, g_b, b_b}), 32'(exp_rgb));
                check($sformatf("b_hs(%0d,%0d)", ex, ey), 32'(hsync_b),
                      (ex == 10 || ex == 11) ? 32'd0 : 32'd1);
                check($sformatf("b_vs(%0d,%0d)", ex, ey), 32'(vsync_b),
                      (ey == 5) ? 32'd0 : 32'd1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
